tc_serial_seq: RTL

- Word-level sequencer for the bit-serial two's-complement unit (`invert`: serial in x, sync clear r, clock, serial out y).
- Accepts a parallel WIDTH-bit word over a valid/ready handshake, clears the serial unit, and shifts the word out LSB-first.
- Collects the serial result into a shift register and presents the complemented word over a second valid/ready handshake.
- Sits between a parallel producer/consumer and one serial complementer instance.

---
 rtl/tc_serial_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/tc_serial_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tc_serial_seq                                                |
// | Description : Word-level sequencer for a bit-serial two's-complement unit. |
// |               Accepts a parallel word, clears the serial unit, shifts the  |
// |               word out LSB-first, collects the serial result and presents  |
// |               the complemented word over a valid/ready handshake.          |
// |               Optional feature macro: TC_SEQ_OVF_DETECT_EN adds out_ovf,   |
// |               flagging that the accepted word was the most-negative value. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tc_serial_seq #(
  parameter int WIDTH   = 8,  // word width, 2..32
  parameter int SER_LAT = 0   // serial unit latency: 0 combinational, 1 registered
) (
  input  logic             t_clock,
  input  logic             r,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ser_x,
  output logic             ser_r,
  input  logic             ser_y,
`ifdef TC_SEQ_OVF_DETECT_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  // Counter must reach WIDTH+SER_LAT-1 (the last sample cycle).
  localparam int                CNT_W   = $clog2(WIDTH + SER_LAT + 1);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(WIDTH + SER_LAT - 1);
  localparam logic [CNT_W-1:0] C_WIDTH = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic             ovalid_q, ovalid_d;
  logic             sample_en;

`ifdef TC_SEQ_OVF_DETECT_EN
  localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic ovf_flag_q, ovf_flag_d;
  logic ovf_q, ovf_d;
  assign out_ovf = ovf_q;
`endif

  // ser_y carries valid result bits only once the serial unit latency has elapsed.
  generate
    if (SER_LAT == 0) begin : g_lat_comb
      assign sample_en = 1'b1;
    end else begin : g_lat_reg
      assign sample_en = (cnt_q != '0);
    end
  endgenerate

  assign out_data  = odata_q;
  assign out_valid = ovalid_q;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge t_clock or negedge r) begin
    if (!r) begin
      state_q  <= ST_IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      cnt_q    <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
`ifdef TC_SEQ_OVF_DETECT_EN
      ovf_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
`ifdef TC_SEQ_OVF_DETECT_EN
      ovf_flag_q <= ovf_flag_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  // Next-state logic and serial-side / handshake outputs.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    cnt_d    = cnt_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
`ifdef TC_SEQ_OVF_DETECT_EN
    ovf_flag_d = ovf_flag_q;
    ovf_d      = ovf_q;
`endif
    in_ready = 1'b0;
    ser_r    = 1'b1;
    ser_x    = 1'b0;
    busy     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tx_d    = in_data;
          cnt_d   = '0;
          state_d = ST_CLEAR;
`ifdef TC_SEQ_OVF_DETECT_EN
          ovf_flag_d = (in_data == C_MOST_NEG);
`endif
        end
      end

      ST_CLEAR: begin
        busy    = 1'b1;
        cnt_d   = '0;
        rx_d    = '0;
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        busy  = 1'b1;
        ser_r = 1'b0;
        // Pad with zeros during the extra latency cycle(s).
        if (cnt_q < C_WIDTH) begin
          ser_x = tx_q[0];
        end
        tx_d = tx_q >> 1;
        if (sample_en) begin
          rx_d = {ser_y, rx_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + C_ONE;
        if (cnt_q == C_LAST) begin
          // rx_d already holds the final sample taken this cycle.
          odata_d  = rx_d;
          ovalid_d = 1'b1;
          state_d  = ST_DONE;
`ifdef TC_SEQ_OVF_DETECT_EN
          ovf_d = ovf_flag_q;
`endif
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          state_d  = ST_IDLE;
`ifdef TC_SEQ_OVF_DETECT_EN
          ovf_d = 1'b0;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
